mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the execute stage and the byte-addressed `ram`. It accepts one RV32I memory request at a time and drives the `ram` enable, read and write strobes. Loads return sign- or zero-extended data; SB/SH use a read-modify-write, because `ram` always reads and writes four little-endian bytes. Results go back to the pipeline with a one-cycle response pulse.

## Interface
Parameters:
- `XLEN`, 32, data width; must match `` `XLEN `` from config.v.
- `ADDR_W`, 32, address width.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  XLEN  store data, taken from the low bytes.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `resp_err`  out  1  illegal funct3 or trapped misalignment; qualified by `resp_valid`.
- `ram_en`, `read_flag`, `write_flag`  out  1 each  `ram` strobes; active level is `` `READ_ENABLE ``/`` `WRITE_ENABLE ``.
- `read_addr`, `write_addr`  out  ADDR_W  `ram` addresses, always equal to the latched `req_addr`.
- `write_data`  out  XLEN  word written to `ram`.
- `read_data`  in  XLEN  `ram` registered read data.

## Operation
- All outputs are registered. Reset value of every output is 0, except `req_ready`, which is 1.
- Handshake:
  - A request is accepted on the edge where `req_valid && req_ready` is true.
  - On acceptance, `req_we`, `req_funct3`, `req_addr` and `req_wdata` are latched.
  - `req_valid` is ignored outside IDLE.
- FSM states:
  - IDLE: strobes low, `ram_en` low. On accept, the next state is:
    - RD for loads, SB and SH;
    - WR for SW;
    - RESP with error set for an illegal request.
  - RD: `ram_en`=1, `read_flag`=1. Next state is WAITR.
  - WAITR: `ram_en`=1 and `read_flag`=0. `ram_en` stays high so that `ram` does not clear `read_data`; `read_data` is valid in this state.
    - Loads: capture the extended value, go to RESP.
    - SB/SH: merge the store bytes into the captured word, go to WR.
  - WR: `ram_en`=1, `write_flag`=1, `write_data` = merged word (SW: `req_wdata` unchanged). Next state is RESP.
  - RESP: `resp_valid`=1 for exactly one cycle. Next state is IDLE.
- Load extension, using `read_data`[7:0] or [15:0] (`ram` is read at the exact byte address):
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Store merge:
  - SB replaces [7:0] of the read word.
  - SH replaces [15:0].
  - Upper bytes are rewritten with their old values.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: anything above 010.
  - Behaviour: no `ram` activity; `resp_err`=1 and `resp_rdata`=0.
- Reset mid-operation:
  - `rst` returns the FSM to IDLE and clears all outputs on the next edge.
  - No pending write is issued afterwards.
  - A write whose WR cycle coincides with the `rst` edge still completes, because `ram` samples `write_flag` on that same edge.

## Timing
Accept edge = k. `resp_valid` is high in the cycle after:
- Load: edge k+3 (RD, WAITR, RESP).
- SW: edge k+2 (WR, RESP).
- SB/SH: edge k+4 (RD, WAITR, WR, RESP).
- Error: edge k+1.
- `req_ready` goes high again in the cycle after RESP. There is no back-to-back overlap; maximum throughput is one SW per 3 cycles.
- `write_flag` and `read_flag` are each high for exactly one cycle per access.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: the following requests are misaligned:
  - LH, LHU or SH with `addr[0]`=1;
  - LW or SW with `addr[1:0]`≠0.
  - Behaviour: treated like an illegal request. Go straight to RESP with `resp_err`=1 and no `ram` access.
- Not defined: misaligned accesses proceed normally, since `ram` is byte-granular. `resp_err` is raised only for illegal funct3.

## Test plan
- `ram` word at 0x100 = 0x8899AABB. LB at 0x101 → `resp_rdata`=0xFFFFFFAA with `resp_valid` at k+3; LBU at the same address → 0x000000AA.
- SW 0x12345678 to 0x200, then LW 0x200 → 0x12345678. `write_flag` is high exactly one cycle; `resp_valid` for the SW at k+2.
- Word at 0x204 = 0x11223344, SH with `req_wdata`=0xCAFEBEEF → LW 0x204 returns 0x1122BEEF; SH `resp_valid` at k+4.
- LH at 0x103:
  - with `MEM_MISALIGN_TRAP_EN`: `resp_err`=1 at k+1, `ram_en` never asserted;
  - without it: returns the sign-extended bytes 0x104:0x103.
- Load with funct3=011 → `resp_err`=1, `resp_rdata`=0 at k+1, no `ram` strobes.
- SB in progress, `rst` high during WAITR → next cycle IDLE with `req_ready`=1 and all other outputs 0. `write_flag` never asserts; the memory word is unchanged.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and ram-side signal bundle for mem_access_unit.
interface mem_access_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              ram_en;
    logic              read_flag;
    logic              write_flag;
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_en, read_flag, write_flag, read_addr, write_addr, write_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_en, read_flag, write_flag, read_addr, write_addr, write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store sequencer in front of the word-wide, byte-addressed ram.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned LH/LHU/SH/LW/SW instead of issuing them.
`ifndef READ_ENABLE
`define READ_ENABLE 1'b1
`endif
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif

module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAITR, S_WR, S_RESP} state_t;

    state_t          state;
    logic            we_p0;
    logic [2:0]      f3_p0;
    logic [XLEN-1:0] wdata_p0;
    logic            misalign;
    logic            req_bad;

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] w);
        logic signed [XLEN-1:0] r;
        case (f3)
            3'b000:  r = XLEN'($signed(w[7:0]));
            3'b001:  r = XLEN'($signed(w[15:0]));
            3'b100:  r = XLEN'(w[7:0]);
            3'b101:  r = XLEN'(w[15:0]);
            default: r = w;
        endcase
        return r;
    endfunction

    // Untouched upper bytes are written back with the value just read.
    function automatic logic [XLEN-1:0] store_merge(input logic [1:0] sz, input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] m;
        m = old;
        case (sz)
            2'b00:   m[7:0]  = wd[7:0];
            2'b01:   m[15:0] = wd[15:0];
            default: m       = wd;
        endcase
        return m;
    endfunction

    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        if (we) return (f3 > 3'b010);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign req_bad = illegal_f3(bus.req_we, bus.req_funct3) || misalign;

    always_ff @(posedge clk) begin
        if (bus.req_valid && state == S_IDLE) begin
            we_p0    <= bus.req_we;
            f3_p0    <= bus.req_funct3;
            wdata_p0 <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.ram_en     <= 1'b0;
            bus.read_flag  <= ~`READ_ENABLE;
            bus.write_flag <= ~`WRITE_ENABLE;
            bus.read_addr  <= '0;
            bus.write_addr <= '0;
            bus.write_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready  <= 1'b0;
                        bus.read_addr  <= bus.req_addr;
                        bus.write_addr <= bus.req_addr;
                        if (req_bad) begin
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
                            state          <= S_WR;
                            bus.ram_en     <= 1'b1;
                            bus.write_flag <= `WRITE_ENABLE;
                            bus.write_data <= bus.req_wdata;
                        end else begin
                            state         <= S_RD;
                            bus.ram_en    <= 1'b1;
                            bus.read_flag <= `READ_ENABLE;
                        end
                    end
                end
                // ram latches the read on this edge; ram_en stays up so read_data holds
                S_RD: begin
                    state         <= S_WAITR;
                    bus.read_flag <= ~`READ_ENABLE;
                end
                S_WAITR: begin
                    if (we_p0) begin
                        state          <= S_WR;
                        bus.write_flag <= `WRITE_ENABLE;
                        bus.write_data <= store_merge(f3_p0[1:0], bus.read_data, wdata_p0);
                    end else begin
                        state          <= S_RESP;
                        bus.ram_en     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= load_ext(f3_p0, bus.read_data);
                    end
                end
                S_WR: begin
                    state          <= S_RESP;
                    bus.ram_en     <= 1'b0;
                    bus.write_flag <= ~`WRITE_ENABLE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                S_RESP: begin
                    state          <= S_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
